idma_mc_error_handler: RTL and testbench

// - Multi-channel successor of the single-channel iDMA error handler. It collects AXI read/write

---
 rtl/idma_mc_error_handler.sv | 200 ++++++++++++++++++++
 tb/tb_idma_mc_error_handler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_mc_error_handler.sv
// Multi-channel iDMA error handler: round-robin collection of backend bus errors, frontend
// decision handling, per-channel credits. Optional error counters via IDMA_MC_EH_ERR_CNT_EN.
module idma_mc_error_handler #(
  parameter int unsigned NumCh     = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned MaxOutst  = 32,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned ChW      = (NumCh > 1) ? $clog2(NumCh) : 1,
  localparam int unsigned CredW    = $clog2(MaxOutst + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumCh-1:0]              err_valid_i,
  output logic [NumCh-1:0]              err_ready_o,
  input  logic [NumCh*AddrWidth-1:0]    err_addr_i,
  input  logic [NumCh*2-1:0]            err_cause_i,
  input  logic [NumCh-1:0]              err_write_i,
  input  logic [NumCh-1:0]              err_last_i,
  input  logic [NumCh-1:0]              launch_i,
  input  logic [NumCh-1:0]              done_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          rsp_error_o,
  output logic [ChW-1:0]                rsp_ch_o,
  output logic [AddrWidth-1:0]          rsp_addr_o,
  output logic [1:0]                    rsp_cause_o,
  output logic                          rsp_write_o,
  input  logic                          eh_valid_i,
  output logic                          eh_ready_o,
  input  logic                          eh_abort_i,
  input  logic [NumCh-1:0]              dp_busy_i,
  output logic [NumCh-1:0]              flush_o,
  output logic [NumCh-1:0]              kill_o,
  output logic [NumCh-1:0]              poison_o,
  output logic                          busy_o,
  output logic                          proto_err_o,
  output logic [NumCh*CntWidth-1:0]     err_cnt_o,
  input  logic                          cnt_clr_i
);

  typedef enum logic [2:0] {StIdle, StReport, StDecide, StFlush, StExtra} state_e;

  state_e               state_q, state_d;
  logic [ChW-1:0]       ptr_q, ptr_d, ch_q, gnt_idx;
  logic                 gnt_found, accept, abort_zero, cred_nz;
  logic [AddrWidth-1:0] addr_q;
  logic [1:0]           cause_q;
  logic                 write_q, last_q;
  logic                 proto_err_q, proto_err_d;
  logic [CredW-1:0]     cred_q [NumCh];
  logic [CredW-1:0]     cred_d [NumCh];

  // First requester at or after the round-robin pointer.
  always_comb begin
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      idx = (32'(ptr_q) + i) % NumCh;
      if (!gnt_found && err_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ChW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_idx == ChW'(NumCh - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    abort_zero  = 1'b0;
    err_ready_o = '0;
    rsp_valid_o = 1'b0;
    rsp_error_o = 1'b0;
    rsp_ch_o    = '0;
    rsp_addr_o  = '0;
    rsp_cause_o = '0;
    rsp_write_o = 1'b0;
    eh_ready_o  = 1'b0;
    flush_o     = '0;
    poison_o    = '0;
    kill_o      = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          accept               = 1'b1;
          err_ready_o[gnt_idx] = 1'b1;
          state_d              = StReport;
        end
      end
      StReport: begin
        rsp_valid_o = 1'b1;
        rsp_error_o = 1'b1;
        rsp_ch_o    = ch_q;
        rsp_addr_o  = addr_q;
        rsp_cause_o = cause_q;
        rsp_write_o = write_q;
        if (rsp_ready_i) state_d = StDecide;
      end
      StDecide: begin
        if (eh_valid_i) begin
          eh_ready_o = 1'b1;
          // Only the last outstanding transfer is worth flushing; otherwise abort acts as continue.
          if (eh_abort_i && cred_q[ch_q] == CredW'(1)) begin
            state_d = StFlush;
          end else begin
            abort_zero = eh_abort_i && (cred_q[ch_q] == '0);
            state_d    = last_q ? StExtra : StIdle;
          end
        end
      end
      StFlush: begin
        flush_o[ch_q]  = 1'b1;
        poison_o[ch_q] = 1'b1;
        if (!dp_busy_i[ch_q]) begin
          kill_o[ch_q] = 1'b1;
          state_d      = StExtra;
        end
      end
      StExtra: begin
        rsp_valid_o = 1'b1;
        rsp_ch_o    = ch_q;
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    proto_err_d = proto_err_q | abort_zero;
    cred_nz     = 1'b0;
    for (int unsigned k = 0; k < NumCh; k++) begin
      cred_d[k] = cred_q[k];
      if (launch_i[k] && !done_i[k]) begin
        if (cred_q[k] == CredW'(MaxOutst)) proto_err_d = 1'b1;
        else cred_d[k] = cred_q[k] + 1'b1;
      end else if (done_i[k] && !launch_i[k]) begin
        if (cred_q[k] == '0) proto_err_d = 1'b1;
        else cred_d[k] = cred_q[k] - 1'b1;
      end
      if (kill_o[k] && cred_d[k] != '0) cred_d[k] = cred_d[k] - 1'b1;
      cred_nz = cred_nz | (cred_q[k] != '0);
    end
  end

  assign busy_o      = (state_q != StIdle) || cred_nz;
  assign proto_err_o = proto_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      ch_q        <= '0;
      addr_q      <= '0;
      cause_q     <= '0;
      write_q     <= 1'b0;
      last_q      <= 1'b0;
      proto_err_q <= 1'b0;
      for (int unsigned k = 0; k < NumCh; k++) cred_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      proto_err_q <= proto_err_d;
      for (int unsigned k = 0; k < NumCh; k++) cred_q[k] <= cred_d[k];
      if (accept) begin
        ch_q    <= gnt_idx;
        addr_q  <= err_addr_i[32'(gnt_idx)*AddrWidth +: AddrWidth];
        cause_q <= err_cause_i[32'(gnt_idx)*2 +: 2];
        write_q <= err_write_i[gnt_idx];
        last_q  <= err_last_i[gnt_idx];
      end
    end
  end

`ifdef IDMA_MC_EH_ERR_CNT_EN
  logic [CntWidth-1:0] cnt_q [NumCh];

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      for (int unsigned k = 0; k < NumCh; k++) cnt_q[k] <= '0;
    end else if (accept && cnt_q[gnt_idx] != '1) begin
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
    end
  end

  for (genvar k = 0; k < NumCh; k++) begin : g_cnt_out
    assign err_cnt_o[k*CntWidth +: CntWidth] = cnt_q[k];
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_idma_mc_error_handler.sv
// Randomized self-checking bench for idma_mc_error_handler against a transaction-level model.
module tb_idma_mc_error_handler;

  localparam int NCH  = 4;
  localparam int AW   = 64;
  localparam int MAXO = 32;
  localparam int CW   = 2;
`ifdef IDMA_MC_EH_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    err_valid_i, err_ready_o, err_write_i, err_last_i;
  logic [NCH*AW-1:0] err_addr_i;
  logic [NCH*2-1:0]  err_cause_i;
  logic [NCH-1:0]    launch_i, done_i, dp_busy_i, flush_o, kill_o, poison_o;
  logic              rsp_valid_o, rsp_ready_i, rsp_error_o, rsp_write_o;
  logic [1:0]        rsp_ch_o, rsp_cause_o;
  logic [AW-1:0]     rsp_addr_o;
  logic              eh_valid_i, eh_ready_o, eh_abort_i, busy_o, proto_err_o, cnt_clr_i;
  logic [NCH*CW-1:0] err_cnt_o;

  idma_mc_error_handler #(
    .NumCh(NCH), .AddrWidth(AW), .MaxOutst(MAXO), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .err_valid_i(err_valid_i), .err_ready_o(err_ready_o),
    .err_addr_i(err_addr_i), .err_cause_i(err_cause_i), .err_write_i(err_write_i),
    .err_last_i(err_last_i), .launch_i(launch_i), .done_i(done_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_error_o(rsp_error_o), .rsp_ch_o(rsp_ch_o),
    .rsp_addr_o(rsp_addr_o), .rsp_cause_o(rsp_cause_o), .rsp_write_o(rsp_write_o),
    .eh_valid_i(eh_valid_i), .eh_ready_o(eh_ready_o), .eh_abort_i(eh_abort_i),
    .dp_busy_i(dp_busy_i), .flush_o(flush_o), .kill_o(kill_o), .poison_o(poison_o),
    .busy_o(busy_o), .proto_err_o(proto_err_o), .err_cnt_o(err_cnt_o), .cnt_clr_i(cnt_clr_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int             cred [NCH];
  int             cnt  [NCH];
  int             ptr;
  bit             perr;
  bit [NCH-1:0]   pending;
  logic [AW-1:0]  p_addr  [NCH];
  logic [1:0]     p_cause [NCH];
  bit             p_write [NCH];
  bit             p_last  [NCH];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*CW-1:0] cnt_exp();
    logic [NCH*CW-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*CW +: CW] = CntEn ? CW'(cnt[k]) : '0;
    return v;
  endfunction

  function automatic bit any_cred();
    bit r;
    r = 1'b0;
    for (int k = 0; k < NCH; k++) if (cred[k] != 0) r = 1'b1;
    return r;
  endfunction

  task automatic drive_err();
    for (int k = 0; k < NCH; k++) begin
      err_addr_i[k*AW +: AW] = p_addr[k];
      err_cause_i[k*2 +: 2]  = p_cause[k];
      err_write_i[k]         = p_write[k];
      err_last_i[k]          = p_last[k];
    end
    err_valid_i = pending;
  endtask

  task automatic post_err(input int ch, input logic [AW-1:0] a, input logic [1:0] c,
                          input bit w, input bit l);
    p_addr[ch] = a; p_cause[ch] = c; p_write[ch] = w; p_last[ch] = l;
    pending[ch] = 1'b1;
    drive_err();
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin cred[k] = 0; cnt[k] = 0; end
    ptr = 0; perr = 1'b0; pending = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; pending = '0; drive_err();
    launch_i = '0; done_i = '0; rsp_ready_i = 0; eh_valid_i = 0; eh_abort_i = 0;
    dp_busy_i = '0; cnt_clr_i = 0;
    tick();
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic idle_checks(input string tag);
    #1;
    check_eq({tag, "_rsp_valid"}, rsp_valid_o, 0);
    check_eq({tag, "_proto"}, proto_err_o, perr);
    check_eq({tag, "_busy"}, busy_o, any_cred());
    check_eq({tag, "_cnt"}, err_cnt_o, cnt_exp());
  endtask

  task automatic cred_cycle(input logic [NCH-1:0] l, input logic [NCH-1:0] d);
    launch_i = l; done_i = d;
    tick();
    launch_i = '0; done_i = '0;
    for (int k = 0; k < NCH; k++) begin
      if (l[k] && !d[k]) begin
        if (cred[k] == MAXO) perr = 1'b1; else cred[k]++;
      end else if (d[k] && !l[k]) begin
        if (cred[k] == 0) perr = 1'b1; else cred[k]--;
      end
    end
  endtask

  // Serves exactly one error report end to end; DUT must be idle with pending != 0.
  task automatic serve(input bit abort, input int rsp_dly, input int eh_dly, input int busy_cyc,
                       input bit clr);
    int g; bit found; bit flush_exp; bit extra_exp;
    found = 0; g = 0;
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (ptr + i) % NCH;
      if (!found && pending[c]) begin found = 1; g = c; end
    end
    cnt_clr_i = clr;
    #1;
    check_eq("err_ready", err_ready_o, 64'(1 << g));
    tick();
    cnt_clr_i = 0;
    if (clr) for (int k = 0; k < NCH; k++) cnt[k] = 0;
    else if (cnt[g] < (1 << CW) - 1) cnt[g]++;
    pending[g] = 1'b0; drive_err();
    ptr = (g + 1) % NCH;
    for (int d = 0; d <= rsp_dly; d++) begin
      rsp_ready_i = (d == rsp_dly);
      #1;
      check_eq("rep_valid", rsp_valid_o, 1);
      check_eq("rep_error", rsp_error_o, 1);
      check_eq("rep_ch", rsp_ch_o, g);
      check_eq("rep_addr", rsp_addr_o, p_addr[g]);
      check_eq("rep_cause", rsp_cause_o, p_cause[g]);
      check_eq("rep_write", rsp_write_o, p_write[g]);
      check_eq("rep_err_ready", err_ready_o, 0);
      tick();
      rsp_ready_i = 0;
    end
    flush_exp = abort && (cred[g] == 1);
    if (abort && cred[g] == 0) perr = 1'b1;
    extra_exp = flush_exp || p_last[g];
    for (int d = 0; d <= eh_dly; d++) begin
      eh_valid_i = (d == eh_dly); eh_abort_i = abort;
      #1;
      check_eq("dec_eh_ready", eh_ready_o, d == eh_dly);
      check_eq("dec_rsp_valid", rsp_valid_o, 0);
      tick();
      eh_valid_i = 0;
    end
    if (flush_exp) begin
      for (int b = 0; b <= busy_cyc; b++) begin
        dp_busy_i = NCH'($urandom);
        dp_busy_i[g] = (b < busy_cyc);
        #1;
        check_eq("flush", flush_o, 64'(1 << g));
        check_eq("poison", poison_o, 64'(1 << g));
        check_eq("kill", kill_o, (b == busy_cyc) ? 64'(1 << g) : 64'h0);
        tick();
      end
      dp_busy_i = '0;
      cred[g]--;
    end
    if (extra_exp) begin
      for (int d = 0; d <= rsp_dly; d++) begin
        rsp_ready_i = (d == rsp_dly);
        #1;
        check_eq("ext_valid", rsp_valid_o, 1);
        check_eq("ext_error", rsp_error_o, 0);
        check_eq("ext_ch", rsp_ch_o, g);
        check_eq("ext_payload", {rsp_addr_o[61:0], rsp_cause_o}, 0);
        check_eq("ext_flush_kill", {flush_o, kill_o}, 0);
        tick();
        rsp_ready_i = 0;
      end
    end
    idle_checks("post");
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin
      p_addr[k] = '0; p_cause[k] = '0; p_write[k] = 0; p_last[k] = 0;
    end
    do_reset();
    tick();
    #1;
    check_eq("rst_outputs", {rsp_valid_o, err_ready_o, busy_o, proto_err_o, eh_ready_o}, 0);
    check_eq("rst_ch_outputs", {flush_o, kill_o, poison_o, err_cnt_o}, 0);

    // Simultaneous ch0/ch3 with pointer 0, twice to confirm pointer wraps to 0
    for (int r = 0; r < 2; r++) begin
      post_err(0, 64'h100 + 64'(r), 2'b01, 0, 0);
      post_err(3, 64'h300 + 64'(r), 2'b11, 1, 0);
      serve(0, 0, 0, 0, 0);
      serve(0, 0, 0, 0, 0);
    end
    post_err(2, 64'h1000, 2'b10, 1, 0);
    serve(0, 1, 1, 0, 0);

    // ch1 with one outstanding transfer, aborted read error, datapath busy 5 cycles
    cred_cycle(4'b0010, 4'b0000);
    post_err(1, 64'hdead_beef_0000_0040, 2'b11, 0, 0);
    serve(1, 0, 0, 5, 0);

    // ch1 with three outstanding transfers: abort must not flush, last=1 gives extra response
    for (int i = 0; i < 3; i++) cred_cycle(4'b0010, 4'b0000);
    post_err(1, 64'h2000, 2'b10, 1, 1);
    serve(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cred_cycle(4'b0000, 4'b0010);
    idle_checks("ch1_drain");

    cred_cycle(4'b0001, 4'b0001);
    idle_checks("launch_done_same");
    cred_cycle(4'b0000, 4'b0001);
    idle_checks("done_at_zero");

    do_reset();
    idle_checks("reset_clears_proto");
    post_err(2, 64'h42, 2'b10, 0, 0);
    serve(1, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i <= MAXO; i++) cred_cycle(4'b0100, 4'b0000);
    idle_checks("launch_overflow");
    for (int i = 0; i < MAXO; i++) cred_cycle(4'b0000, 4'b0100);
    idle_checks("overflow_drain");

    do_reset();
    for (int i = 0; i < 5; i++) begin
      post_err(3, AW'($urandom), 2'($urandom), 1'($urandom), 0);
      serve(0, 0, 0, 0, 0);
    end
    cnt_clr_i = 1; tick(); cnt_clr_i = 0;
    for (int k = 0; k < NCH; k++) cnt[k] = 0;
    idle_checks("cnt_clear");
    post_err(3, 64'h77, 2'b01, 0, 0);
    serve(0, 0, 0, 0, 1);

    // Randomized mix of credit traffic and error reports
    do_reset();
    for (int it = 0; it < 80; it++) begin
      if (pending == '0 && $urandom_range(0, 2) == 0) begin
        for (int c = 0; c < $urandom_range(1, 4); c++)
          cred_cycle(NCH'($urandom & $urandom), NCH'($urandom & $urandom));
        idle_checks("rand_cred");
      end else begin
        for (int k = 0; k < NCH; k++)
          if (!pending[k] && $urandom_range(0, 2) == 0)
            post_err(k, {32'($urandom), 32'($urandom)}, 2'($urandom), 1'($urandom),
                     1'($urandom));
        if (pending == '0)
          post_err($urandom_range(0, NCH - 1), AW'($urandom), 2'($urandom), 1'($urandom),
                   1'($urandom));
        serve(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
              ($urandom_range(0, 15) == 0));
      end
    end
    while (pending != '0) serve(0, 0, 0, 0, 0);

    // Reset while a report is outstanding drops it
    do_reset();
    post_err(1, 64'habc, 2'b11, 0, 1);
    #1;
    check_eq("mid_accept", err_ready_o, 4'b0010);
    tick();
    pending = '0; drive_err();
    rst_i = 1'b1;
    #1;
    check_eq("mid_report", rsp_valid_o, 1);
    tick();
    rst_i = 1'b0;
    model_reset();
    idle_checks("mid_reset");
    tick();
    idle_checks("mid_reset_hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
